// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one dense layer on a single time-shared MAC.
// For each of N_OUT neurons it does three things:
//   - streams N_IN activation/weight pairs from synchronous-read RAMs and
//     accumulates their products;
//   - adds the neuron's bias;
//   - applies optional ReLU plus saturation, then writes one activation.
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   start, relu_en     pass request (accepted in IDLE); ReLU enable latched with start
//   busy, done         busy during ACC/DRAIN/WRITE; done is a one-cycle pulse
//   in_addr/in_data    activation RAM (data valid one cycle after address)
//   w_addr/w_data      weight RAM, layout j*N_IN + k
//   b_addr/b_data      bias RAM, one entry per neuron
//   out_we/out_addr/out_data  output buffer write port
module layer_sequencer #(
  parameter int N_IN   = 196,
  parameter int N_OUT  = 10,
  parameter int latime = 8,
  parameter int IN_AW  = $clog2(N_IN),
  parameter int W_AW   = $clog2(N_IN * N_OUT),
  parameter int OUT_AW = $clog2(N_OUT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       relu_en,
  output logic                       busy,
  output logic                       done,
  output logic [IN_AW-1:0]           in_addr,
  input  logic signed [2*latime-1:0] in_data,
  output logic [W_AW-1:0]            w_addr,
  input  logic signed [latime-1:0]   w_data,
  output logic [OUT_AW-1:0]          b_addr,
  input  logic signed [latime-1:0]   b_data,
  output logic                       out_we,
  output logic [OUT_AW-1:0]          out_addr,
  output logic signed [2*latime-1:0] out_data
);

  localparam int AW = 2 * latime;  // activation width
  localparam int PW = 3 * latime;  // product width
  localparam int CW = 4 * latime;  // accumulator width

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, WRITE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [IN_AW-1:0]       k_reg, k_next;
  logic [OUT_AW-1:0]      j_reg, j_next;
  logic [W_AW-1:0]        w_ptr_reg, w_ptr_next;
  logic signed [CW-1:0]   acc_reg, acc_next;
  logic signed [latime-1:0] bias_reg, bias_next;
  logic                   relu_reg, relu_next;

  // Address/data outputs hold the last value issued once the FSM leaves
  // the state that drives them.
  logic [IN_AW-1:0]       in_addr_hold_reg, in_addr_hold_next;
  logic [W_AW-1:0]        w_addr_hold_reg, w_addr_hold_next;
  logic [OUT_AW-1:0]      b_addr_hold_reg, b_addr_hold_next;
  logic [OUT_AW-1:0]      out_addr_hold_reg, out_addr_hold_next;
  logic signed [AW-1:0]   out_data_hold_reg, out_data_hold_next;

  logic signed [PW-1:0]   prod;
  logic signed [CW-1:0]   prod_ext;
  logic signed [CW-1:0]   sum;
  logic signed [AW-1:0]   result;

  always_comb begin
    // Full-precision signed product, sign-extended into the accumulator.
    prod     = $signed({{latime{in_data[AW-1]}}, in_data}) *
               $signed({{(2*latime){w_data[latime-1]}}, w_data});
    prod_ext = {{latime{prod[PW-1]}}, prod};
    sum      = acc_reg + {{(3*latime){bias_reg[latime-1]}}, bias_reg};

    if (relu_reg && sum[CW-1]) begin
      result = '0;
    end else if (sum > SAT_MAX) begin
      result = SAT_MAX[AW-1:0];
    end else if (sum < SAT_MIN) begin
      result = SAT_MIN[AW-1:0];
    end else begin
      result = sum[AW-1:0];
    end

    state_next         = state_reg;
    k_next             = k_reg;
    j_next             = j_reg;
    w_ptr_next         = w_ptr_reg;
    acc_next           = acc_reg;
    bias_next          = bias_reg;
    relu_next          = relu_reg;
    in_addr_hold_next  = in_addr_hold_reg;
    w_addr_hold_next   = w_addr_hold_reg;
    b_addr_hold_next   = b_addr_hold_reg;
    out_addr_hold_next = out_addr_hold_reg;
    out_data_hold_next = out_data_hold_reg;

    busy     = 1'b0;
    done     = 1'b0;
    out_we   = 1'b0;
    in_addr  = in_addr_hold_reg;
    w_addr   = w_addr_hold_reg;
    b_addr   = b_addr_hold_reg;
    out_addr = out_addr_hold_reg;
    out_data = out_data_hold_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACC;
          k_next     = '0;
          j_next     = '0;
          w_ptr_next = '0;
          relu_next  = relu_en;
        end
      end

      ACC: begin
        busy              = 1'b1;
        in_addr           = k_reg;
        w_addr            = w_ptr_reg;
        in_addr_hold_next = k_reg;
        w_addr_hold_next  = w_ptr_reg;
        // Weights of consecutive neurons are contiguous, so a free-running
        // pointer tracks j*N_IN + k without a multiplier.
        w_ptr_next        = w_ptr_reg + W_AW'(1);
        if (k_reg == '0) begin
          // Data on the read ports belongs to the previous neuron: drop it.
          b_addr           = j_reg;
          b_addr_hold_next = j_reg;
          acc_next         = '0;
        end else begin
          acc_next = acc_reg + prod_ext;
        end
        if (k_reg == IN_AW'(1)) begin
          bias_next = b_data;
        end
        if (k_reg == K_LAST) begin
          state_next = DRAIN;
        end else begin
          k_next = k_reg + IN_AW'(1);
        end
      end

      DRAIN: begin
        busy       = 1'b1;
        acc_next   = acc_reg + prod_ext;
        state_next = WRITE;
      end

      WRITE: begin
        busy               = 1'b1;
        out_we             = 1'b1;
        out_addr           = j_reg;
        out_data           = result;
        out_addr_hold_next = j_reg;
        out_data_hold_next = result;
        if (j_reg == J_LAST) begin
          state_next = DONE;
        end else begin
          j_next     = j_reg + OUT_AW'(1);
          k_next     = '0;
          state_next = ACC;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      k_reg             <= '0;
      j_reg             <= '0;
      w_ptr_reg         <= '0;
      acc_reg           <= '0;
      bias_reg          <= '0;
      relu_reg          <= 1'b0;
      in_addr_hold_reg  <= '0;
      w_addr_hold_reg   <= '0;
      b_addr_hold_reg   <= '0;
      out_addr_hold_reg <= '0;
      out_data_hold_reg <= '0;
    end else begin
      state_reg         <= state_next;
      k_reg             <= k_next;
      j_reg             <= j_next;
      w_ptr_reg         <= w_ptr_next;
      acc_reg           <= acc_next;
      bias_reg          <= bias_next;
      relu_reg          <= relu_next;
      in_addr_hold_reg  <= in_addr_hold_next;
      w_addr_hold_reg   <= w_addr_hold_next;
      b_addr_hold_reg   <= b_addr_hold_next;
      out_addr_hold_reg <= out_addr_hold_next;
      out_data_hold_reg <= out_data_hold_next;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed testbench for layer_sequencer with N_IN=4, N_OUT=3, latime=8.
// Behavioural synchronous-read RAMs feed the DUT; a negedge monitor records
// every output write and done pulse with its cycle number relative to the
// accepting start edge (the cycle after that edge is cycle 1).
module tb_layer_sequencer;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int LATIME = 8;

  logic               clock;
  logic               reset;
  logic               start;
  logic               relu_en;
  logic               busy;
  logic               done;
  logic [1:0]         in_addr;
  logic signed [15:0] in_data;
  logic [3:0]         w_addr;
  logic signed [7:0]  w_data;
  logic [1:0]         b_addr;
  logic signed [7:0]  b_data;
  logic               out_we;
  logic [1:0]         out_addr;
  logic signed [15:0] out_data;

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .latime(LATIME)) dut (
    .clock(clock), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memories
  logic signed [15:0] act_mem [0:3];
  logic signed [7:0]  w_mem   [0:15];
  logic signed [7:0]  b_mem   [0:3];

  always @(posedge clock) begin
    in_data <= act_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  // Cycle bookkeeping and write monitor
  int edge_cnt  = 0;
  int base_edge = 0;
  int wr_n      = 0;
  int done_n    = 0;
  int done_cyc  = 0;
  int wr_addr [0:63];
  int wr_data [0:63];
  int wr_cyc  [0:63];

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (out_we && wr_n < 64) begin
      wr_addr[wr_n] <= int'(out_addr);
      wr_data[wr_n] <= int'(out_data);
      wr_cyc[wr_n]  <= edge_cnt - base_edge + 1;
      wr_n          <= wr_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= edge_cnt - base_edge + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_s1();
    for (int i = 0; i < 4; i++) act_mem[i] = 16'(i + 1);
    for (int i = 0; i < 16; i++) w_mem[i] = 8'sd0;
    for (int i = 0; i < 4; i++) begin
      w_mem[i]     = 8'sd1;
      w_mem[4 + i] = -8'sd1;
    end
    w_mem[8] = 8'sd2;
    b_mem[0] = 8'sd0;
    b_mem[1] = 8'sd5;
    b_mem[2] = -8'sd3;
    b_mem[3] = 8'sd0;
  endtask

  // Starts a pass at the current negedge, then walks ncyc cycles. start is
  // re-pulsed in cycles pa/pb and reset asserted in cycle rc (-1 = never).
  // Returns at the negedge of cycle ncyc+1.
  task automatic run_pass(input logic relu, input int pa, input int pb,
                          input int rc, input int ncyc);
    relu_en = relu;
    start   = 1'b1;
    @(posedge clock);
    #1 base_edge = edge_cnt;
    @(negedge clock);
    for (int c = 1; c <= ncyc; c++) begin
      start = (c == pa) || (c == pb);
      reset = (c == rc);
      if (c == 1) check("busy_cycle1", int'(busy), 1);
      if (rc > 0 && c == rc + 1) begin
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_out_we", int'(out_we), 0);
      end
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic check_writes(input string pfx, input int wb,
                              input int e0, input int e1, input int e2);
    int exp_d [0:2];
    exp_d[0] = e0;
    exp_d[1] = e1;
    exp_d[2] = e2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_w%0d_addr", pfx, i), wr_addr[wb + i], i);
      check($sformatf("%s_w%0d_data", pfx, i), wr_data[wb + i], exp_d[i]);
    end
  endtask

  int wb;
  int db;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    relu_en = 1'b0;
    load_s1();
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_we", int'(out_we), 0);
    check("rst_in_addr", int'(in_addr), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    reset = 1'b0;
    @(negedge clock);

    // 1. Basic pass, ReLU on
    wb = wr_n; db = done_n;
    run_pass(1'b1, -1, -1, -1, 22);
    check("s1_writes", wr_n - wb, 3);
    check("s1_dones", done_n - db, 1);
    check("s1_done_cycle", done_cyc, 19);
    check_writes("s1", wb, 10, 0, 0);
    check("s1_w0_cycle", wr_cyc[wb], 6);
    check("s1_w1_cycle", wr_cyc[wb + 1], 12);
    check("s1_w2_cycle", wr_cyc[wb + 2], 18);
    check("s1_idle_busy", int'(busy), 0);
    $display("pass s1 relu=1: writes %0d/%0d/%0d done_cycle=%0d",
             wr_data[wb], wr_data[wb + 1], wr_data[wb + 2], done_cyc);

    // 2. ReLU off
    wb = wr_n;
    run_pass(1'b0, -1, -1, -1, 22);
    check("s2_writes", wr_n - wb, 3);
    check_writes("s2", wb, 10, -5, -1);
    $display("pass s2 relu=0: writes %0d/%0d/%0d",
             wr_data[wb], wr_data[wb + 1], wr_data[wb + 2]);

    // 3. Saturation, positive then negative
    for (int i = 0; i < 4; i++) begin
      act_mem[i] = 16'sd32767;
      w_mem[i]   = 8'sd127;
    end
    b_mem[0] = 8'sd127;
    wb = wr_n;
    run_pass(1'b1, -1, -1, -1, 22);
    check("s3_pos_sat", wr_data[wb], 32767);
    $display("pass s3 positive saturation: neuron0=%0d", wr_data[wb]);
    for (int i = 0; i < 4; i++) w_mem[i] = -8'sd128;
    wb = wr_n;
    run_pass(1'b0, -1, -1, -1, 22);
    check("s3_neg_sat", wr_data[wb], -32768);
    $display("pass s3 negative saturation: neuron0=%0d", wr_data[wb]);

    // 4. start pulses while busy and in the DONE cycle are ignored
    load_s1();
    wb = wr_n; db = done_n;
    run_pass(1'b1, 3, 19, -1, 24);
    check("s4_writes", wr_n - wb, 3);
    check("s4_dones", done_n - db, 1);
    check("s4_busy_after", int'(busy), 0);
    check_writes("s4", wb, 10, 0, 0);
    $display("pass s4 ignored starts: writes=%0d dones=%0d", wr_n - wb, done_n - db);

    // 5. Reset mid-pass, then a clean pass
    wb = wr_n; db = done_n;
    run_pass(1'b1, -1, -1, 8, 14);
    check("s5_writes_before_rst", wr_n - wb, 1);
    check("s5_no_done", done_n - db, 0);
    wb = wr_n; db = done_n;
    run_pass(1'b1, -1, -1, -1, 22);
    check("s5_fresh_writes", wr_n - wb, 3);
    check("s5_fresh_done_cycle", done_cyc, 19);
    check_writes("s5", wb, 10, 0, 0);
    $display("pass s5 after reset: writes %0d/%0d/%0d",
             wr_data[wb], wr_data[wb + 1], wr_data[wb + 2]);

    // 6. Back-to-back passes, new activations for the second one
    wb = wr_n; db = done_n;
    run_pass(1'b0, -1, -1, -1, 19);
    act_mem[0] = -16'sd1;
    act_mem[1] = 16'sd5;
    act_mem[2] = 16'sd0;
    act_mem[3] = 16'sd2;
    run_pass(1'b0, -1, -1, -1, 22);
    check("s6_writes", wr_n - wb, 6);
    check("s6_dones", done_n - db, 2);
    check("s6_done_cycle2", done_cyc, 19);
    check_writes("s6a", wb, 10, -5, -1);
    check_writes("s6b", wb + 3, 6, -1, -5);
    $display("pass s6 back-to-back: second writes %0d/%0d/%0d",
             wr_data[wb + 3], wr_data[wb + 4], wr_data[wb + 5]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences one dense layer on a single time-shared MAC.
- For each of N_OUT output neurons it:
  - streams N_IN input activations and N_IN weights from synchronous-read memories;
  - accumulates the products;
  - adds the neuron's bias;
  - applies optional ReLU and saturation;
  - writes one activation to the output buffer.
- Sits between the layer-level control FSM (start/done) and the activation/weight/bias RAMs.
- One instance per layer; outputs feed the next layer's input buffer.

Parameters:
- N_IN, 196, inputs per neuron (≥2)
- N_OUT, 10, neurons in the layer (≥1)
- latime, 8, base width: weight/bias = latime, activation = 2*latime, accumulator = 4*latime
- IN_AW, $clog2(N_IN), input address width
- W_AW, $clog2(N_IN*N_OUT), weight address width
- OUT_AW, $clog2(N_OUT), bias/output address width

Ports:
- clock, input, 1, single clock, all logic on rising edge
- reset, input, 1, synchronous active-high reset
- start, input, 1, request a layer pass; sampled only in IDLE
- relu_en, input, 1, ReLU enable; sampled with accepted start
- busy, output, 1, high from the cycle after start is accepted until DONE
- done, output, 1, one-cycle pulse at end of pass
- in_addr, output, IN_AW, activation RAM read address
- in_data, input, 2*latime signed, activation; valid one cycle after in_addr
- w_addr, output, W_AW, weight RAM read address
- w_data, input, latime signed, weight; valid one cycle after w_addr
- b_addr, output, OUT_AW, bias RAM read address
- b_data, input, latime signed, bias; valid one cycle after b_addr
- out_we, output, 1, output write strobe
- out_addr, output, OUT_AW, output write address
- out_data, output, 2*latime signed, output activation

Behaviour:
- Reset:
  - state = IDLE; busy, done, out_we = 0.
  - All addresses = 0; out_data = 0.
  - Accumulator, neuron index j and input index k cleared.
  - Reset mid-pass aborts immediately: no further out_we, no done.
- States: IDLE, ACC, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 → ACC; j=0, k=0; relu_en latched.
  - start while not IDLE is ignored.
- ACC, one cycle per k:
  - in_addr = k; w_addr = j*N_IN + k.
  - When k=0: b_addr = j, and accumulator cleared (not added).
  - Data issued for k−1 is accumulated this cycle: acc <= acc + in_data*w_data, signed, full 3*latime product sign-extended to 4*latime.
  - Bias is latched the cycle after k=0.
  - k = N_IN−1 → DRAIN; else k++.
- DRAIN: accumulates the last product (k = N_IN−1) → WRITE.
- WRITE:
  - s = acc + sign-extended bias.
  - If relu_en and s<0 → 0; else saturate s to [−2^(2*latime−1), 2^(2*latime−1)−1].
  - out_data = result, out_addr = j, out_we = 1 for exactly this cycle.
  - j = N_OUT−1 → DONE; else j++, k=0 → ACC.
- DONE: done = 1 for one cycle, busy = 0 → IDLE. A start in the DONE cycle is ignored.
- Timing:
  - Each neuron takes N_IN+2 cycles.
  - With start accepted at edge 0, done is high in cycle N_OUT*(N_IN+2)+1.
- busy is 1 in ACC, DRAIN and WRITE.
- Accumulator is wraparound, not saturating; 4*latime bits is sufficient for the default parameters.
- Address outputs hold their last value outside ACC; RAM reads are side-effect free.

Test Plan:
All scenarios use N_IN=4, N_OUT=3, latime=8.
1. Basic pass:
   - Stimulus: in=[1,2,3,4]; neuron0 w=[1,1,1,1] b=0; neuron1 w=[−1,−1,−1,−1] b=5; neuron2 w=[2,0,0,0] b=−3; relu_en=1.
   - Required: writes (0,10), (1,0), (2,−1→0 under ReLU).
   - Required: done in cycle 19; exactly 3 out_we pulses, each 6 cycles apart.
2. ReLU off:
   - Stimulus: same data as scenario 1, relu_en=0.
   - Required: out_data = 10, −5, −1.
3. Saturation:
   - Stimulus: in all 32767, neuron0 w all 127, b=127.
   - Required: out_data 32767.
   - Stimulus (relu_en=0): w all −128.
   - Required: out_data −32768.
4. Start ignored while busy:
   - Stimulus: pulse start at cycles 3 and 19 (the DONE cycle).
   - Required: single pass only; exactly 3 writes; no restart.
5. Reset mid-pass:
   - Stimulus: assert reset in cycle 8 (neuron1 ACC).
   - Required: next cycle busy=0, out_we=0, no done.
   - Required: a fresh start afterwards yields the correct scenario-1 results, with no stale accumulator.
6. Back-to-back passes:
   - Stimulus: start in the first IDLE cycle after done, with changed input data.
   - Required: second pass results reflect the new data only; bias and accumulator are reloaded per neuron.
